// File: rtl/mque_wr_ctrl.sv
// mque_wr_ctrl: packet-aware enqueue controller for the mque_ff write side.
// Admits or drops whole packets per destination queue using af/ff flags.
// Ports: clksw/resetw; in_* beat stream (vld/rdy/sop/eop/port/data);
//   wr/wport/wdata FIFO write; af/ff flags in; drop_cntx per-port
//   saturating drop counters; trunc_err/orphan_err one-cycle pulses.
module mque_wr_ctrl #(
   parameter int PORT_WIDTH     = 1,
   parameter int PORT_NUM       = 2,
   parameter int DATA_WIDTH     = 72,
   parameter int MAX_PKT_BEATS  = 8,
   parameter int BEAT_CNT_WIDTH = 4,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                               clksw,
   input  logic                               resetw,
   input  logic                               in_vld,
   output logic                               in_rdy,
   input  logic                               in_sop,
   input  logic                               in_eop,
   input  logic [PORT_WIDTH-1:0]              in_port,
   input  logic [DATA_WIDTH-1:0]              in_data,
   output logic                               wr,
   output logic [PORT_WIDTH-1:0]              wport,
   output logic [DATA_WIDTH-1:0]              wdata,
   input  logic [PORT_NUM-1:0]                af,
   input  logic [PORT_NUM-1:0]                ff,
   output logic [DROP_CNT_WIDTH*PORT_NUM-1:0] drop_cntx,
   output logic                               trunc_err,
   output logic                               orphan_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam logic [BEAT_CNT_WIDTH-1:0] MAX_CNT =
      BEAT_CNT_WIDTH'(MAX_PKT_BEATS);

   state_t                    state_q, state_d;
   logic [BEAT_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [PORT_WIDTH-1:0]     lock_q, lock_d;
   logic                      rdy_q;
   logic                      wr_q, wr_d;
   logic [PORT_WIDTH-1:0]     wport_q, wport_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic                      trunc_q, trunc_d;
   logic                      orphan_q, orphan_d;
   logic [PORT_NUM-1:0]       drop_inc;
   logic [DROP_CNT_WIDTH-1:0] drop_q [PORT_NUM];
   logic                      acc;

   assign acc = in_vld & rdy_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lock_d   = lock_q;
      wr_d     = 1'b0;
      wport_d  = wport_q;
      wdata_d  = wdata_q;
      trunc_d  = 1'b0;
      orphan_d = 1'b0;
      drop_inc = '0;
      if (acc) begin
         unique case (state_q)
            IDLE: begin
               if (!in_sop) begin
                  orphan_d = 1'b1;
               end else if (af[in_port] | ff[in_port]) begin
                  drop_inc[in_port] = 1'b1;
                  if (!in_eop) state_d = DROP;
               end else begin
                  wr_d    = 1'b1;
                  wport_d = in_port;
                  wdata_d = in_data;
                  lock_d  = in_port;
                  cnt_d   = BEAT_CNT_WIDTH'(1);
                  if (!in_eop) state_d = PASS;
               end
            end
            PASS: begin
               if (ff[lock_q]) begin
                  trunc_d = 1'b1;
                  state_d = in_eop ? IDLE : DROP;
               end else if (cnt_q == MAX_CNT && !in_eop) begin
                  // oversize: rest of packet is discarded
                  trunc_d = 1'b1;
                  state_d = DROP;
               end else begin
                  wr_d    = 1'b1;
                  wport_d = lock_q;
                  wdata_d = in_data;
                  cnt_d   = cnt_q + BEAT_CNT_WIDTH'(1);
                  if (in_eop) state_d = IDLE;
               end
            end
            DROP: begin
               if (in_eop) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clksw or posedge resetw) begin
      if (resetw) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         lock_q   <= '0;
         rdy_q    <= 1'b0;
         wr_q     <= 1'b0;
         wport_q  <= '0;
         wdata_q  <= '0;
         trunc_q  <= 1'b0;
         orphan_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lock_q   <= lock_d;
         rdy_q    <= 1'b1;
         wr_q     <= wr_d;
         wport_q  <= wport_d;
         wdata_q  <= wdata_d;
         trunc_q  <= trunc_d;
         orphan_q <= orphan_d;
      end
   end

   always_ff @(posedge clksw or posedge resetw) begin
      if (resetw) begin
         for (int k = 0; k < PORT_NUM; k++) drop_q[k] <= '0;
      end else begin
         for (int k = 0; k < PORT_NUM; k++) begin
            if (drop_inc[k] && drop_q[k] != '1)
               drop_q[k] <= drop_q[k] + DROP_CNT_WIDTH'(1);
         end
      end
   end

   for (genvar g = 0; g < PORT_NUM; g++) begin : g_drop
      assign drop_cntx[DROP_CNT_WIDTH*(g+1)-1 -: DROP_CNT_WIDTH] = drop_q[g];
   end

   assign in_rdy     = rdy_q;
   assign wr         = wr_q;
   assign wport      = wport_q;
   assign wdata      = wdata_q;
   assign trunc_err  = trunc_q;
   assign orphan_err = orphan_q;

endmodule

// File: tb/tb_mque_wr_ctrl.sv
// tb_mque_wr_ctrl: self-checking bench for mque_wr_ctrl.
// Vector table, directed corner sequences and random packets vs a model.
module tb_mque_wr_ctrl;

   localparam int PW   = 1;
   localparam int PN   = 2;
   localparam int DW   = 72;
   localparam int MAXB = 8;
   localparam int CW   = 16;

   logic               clksw = 1'b0;
   logic               resetw = 1'b1;
   logic               in_vld = 1'b0;
   logic               in_rdy;
   logic               in_sop = 1'b0;
   logic               in_eop = 1'b0;
   logic [PW-1:0]      in_port = '0;
   logic [DW-1:0]      in_data = '0;
   logic               wr;
   logic [PW-1:0]      wport;
   logic [DW-1:0]      wdata;
   logic [PN-1:0]      af = '0;
   logic [PN-1:0]      ff = '0;
   logic [CW*PN-1:0]   drop_cntx;
   logic               trunc_err;
   logic               orphan_err;

   mque_wr_ctrl dut (
      .clksw(clksw), .resetw(resetw),
      .in_vld(in_vld), .in_rdy(in_rdy),
      .in_sop(in_sop), .in_eop(in_eop),
      .in_port(in_port), .in_data(in_data),
      .wr(wr), .wport(wport), .wdata(wdata),
      .af(af), .ff(ff),
      .drop_cntx(drop_cntx),
      .trunc_err(trunc_err), .orphan_err(orphan_err)
   );

   always #5 clksw = ~clksw;

   int checks = 0;
   int errors = 0;
   int quiet_err = 0;

   // packet-level reference state
   bit            m_rdy;
   bit            m_in_pkt;
   bit            m_ok;
   logic [PW-1:0] m_port;
   logic [DW-1:0] m_wdata;
   int            m_written;
   int            m_drops [PN];

   typedef struct {
      bit            v, s, e;
      logic [PW-1:0] p;
      logic [DW-1:0] d;
      logic [PN-1:0] a, f;
      bit            xw, xt, xo;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string n, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_rdy = 0; m_in_pkt = 0; m_ok = 0; m_port = '0;
      m_wdata = '0; m_written = 0;
      for (int k = 0; k < PN; k++) m_drops[k] = 0;
   endtask

   function automatic logic [CW*PN-1:0] exp_drops();
      logic [CW*PN-1:0] r;
      for (int k = 0; k < PN; k++) r[CW*k +: CW] = CW'(m_drops[k]);
      return r;
   endfunction

   task automatic model(input bit acc, s, e, input logic [PW-1:0] p,
                        input logic [DW-1:0] d, input logic [PN-1:0] a, f,
                        output bit xw, xt, xo);
      xw = 0; xt = 0; xo = 0;
      if (acc) begin
         if (!m_in_pkt) begin
            if (!s) xo = 1;
            else begin
               m_in_pkt = !e;
               if (a[p] | f[p]) begin
                  if (m_drops[p] < 65535) m_drops[p]++;
                  m_ok = 0;
               end else begin
                  xw = 1; m_port = p; m_wdata = d;
                  m_written = 1; m_ok = 1;
               end
            end
         end else if (m_ok) begin
            if (f[m_port]) begin
               xt = 1; m_ok = 0; m_in_pkt = !e;
            end else if (m_written >= MAXB && !e) begin
               xt = 1; m_ok = 0;
            end else begin
               xw = 1; m_wdata = d; m_written++; m_in_pkt = !e;
            end
         end else begin
            m_in_pkt = !e;
         end
      end
   endtask

   task automatic step(input bit v, s, e, input logic [PW-1:0] p,
                       input logic [DW-1:0] d, input logic [PN-1:0] a, f,
                       input bit chk_en, output bit xw, xt, xo);
      in_vld = v; in_sop = s; in_eop = e; in_port = p;
      in_data = d; af = a; ff = f;
      model(v & m_rdy, s, e, p, d, a, f, xw, xt, xo);
      @(posedge clksw);
      m_rdy = 1;
      @(negedge clksw);
      if (chk_en) begin
         chk("in_rdy", 128'(in_rdy), 128'(1));
         chk("wr", 128'(wr), 128'(xw));
         if (xw) chk("wport", 128'(wport), 128'(m_port));
         chk("wdata", 128'(wdata), 128'(m_wdata));
         chk("trunc_err", 128'(trunc_err), 128'(xt));
         chk("orphan_err", 128'(orphan_err), 128'(xo));
         chk("drop_cntx", 128'(drop_cntx), 128'(exp_drops()));
      end else if (wr !== xw || trunc_err !== xt || orphan_err !== xo ||
                   drop_cntx !== exp_drops()) begin
         quiet_err++;
      end
   endtask

   function automatic vec_t mk(bit v, s, e, logic [PW-1:0] p,
                               logic [DW-1:0] d, logic [PN-1:0] a, f,
                               bit xw, xt, xo);
      vec_t r;
      r.v = v; r.s = s; r.e = e; r.p = p; r.d = d;
      r.a = a; r.f = f; r.xw = xw; r.xt = xt; r.xo = xo;
      return r;
   endfunction

   initial begin
      bit xw, xt, xo;
      int nw, nt, tat;
      logic [DW-1:0] rd;
      bit s, e, v;

      tbl[0]  = mk(0,0,0,0,72'h0,   2'b00,2'b00, 0,0,0);
      tbl[1]  = mk(1,1,0,1,72'hD0,  2'b00,2'b00, 1,0,0);
      tbl[2]  = mk(1,0,0,1,72'hD1,  2'b00,2'b00, 1,0,0);
      tbl[3]  = mk(1,0,1,1,72'hD2,  2'b00,2'b00, 1,0,0);
      tbl[4]  = mk(1,1,0,0,72'hA0,  2'b01,2'b00, 0,0,0);
      tbl[5]  = mk(1,0,0,0,72'hA1,  2'b01,2'b00, 0,0,0);
      tbl[6]  = mk(1,0,0,0,72'hA2,  2'b01,2'b00, 0,0,0);
      tbl[7]  = mk(1,0,1,0,72'hA3,  2'b01,2'b00, 0,0,0);
      tbl[8]  = mk(1,1,1,1,72'hB0,  2'b01,2'b00, 1,0,0);
      tbl[9]  = mk(1,0,0,0,72'hC0,  2'b00,2'b00, 0,0,1);
      tbl[10] = mk(0,0,0,0,72'hC1,  2'b00,2'b00, 0,0,0);
      tbl[11] = mk(1,1,0,1,72'hE1,  2'b00,2'b00, 1,0,0);
      tbl[12] = mk(1,0,0,1,72'hE2,  2'b00,2'b00, 1,0,0);
      tbl[13] = mk(1,0,0,1,72'hE3,  2'b00,2'b10, 0,1,0);
      tbl[14] = mk(1,0,0,1,72'hE4,  2'b00,2'b10, 0,0,0);
      tbl[15] = mk(1,0,1,1,72'hE5,  2'b00,2'b00, 0,0,0);
      tbl[16] = mk(1,1,1,0,72'hF0,  2'b00,2'b00, 1,0,0);

      m_reset();
      repeat (2) @(negedge clksw);
      chk("rst_in_rdy", 128'(in_rdy), 128'(0));
      chk("rst_wr", 128'(wr), 128'(0));
      chk("rst_wport", 128'(wport), 128'(0));
      chk("rst_wdata", 128'(wdata), 128'(0));
      chk("rst_drop", 128'(drop_cntx), 128'(0));
      chk("rst_trunc", 128'(trunc_err), 128'(0));
      chk("rst_orphan", 128'(orphan_err), 128'(0));
      resetw = 1'b0;

      for (int i = 0; i < 17; i++) begin
         step(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].p, tbl[i].d,
              tbl[i].a, tbl[i].f, 1, xw, xt, xo);
         chk($sformatf("tbl%0d_wr", i), 128'(wr), 128'(tbl[i].xw));
         chk($sformatf("tbl%0d_trunc", i), 128'(trunc_err), 128'(tbl[i].xt));
         chk($sformatf("tbl%0d_orphan", i), 128'(orphan_err), 128'(tbl[i].xo));
         if (tbl[i].xw)
            chk($sformatf("tbl%0d_wdata", i), 128'(wdata), 128'(tbl[i].d));
      end
      chk("tbl_drops", 128'(drop_cntx), {96'd0, 16'd0, 16'd1});

      // 10-beat packet: 8 writes, truncation on beat 9
      nw = 0; nt = 0; tat = -1;
      for (int i = 0; i < 10; i++) begin
         step(1, i == 0, i == 9, 0, DW'(100 + i), 2'b00, 2'b00, 1, xw, xt, xo);
         nw += int'(wr);
         if (trunc_err) begin nt++; tat = i; end
      end
      chk("ovs_writes", 128'(nw), 128'(8));
      chk("ovs_truncs", 128'(nt), 128'(1));
      chk("ovs_trunc_beat", 128'(tat), 128'(8));
      step(1, 1, 1, 1, 72'h77, 2'b00, 2'b00, 1, xw, xt, xo);
      chk("ovs_next_wr", 128'(wr), 128'(1));

      // random packets against the model
      for (int i = 0; i < 1500; i++) begin
         v = ($urandom_range(0, 3) != 0);
         s = ($urandom_range(0, 5) == 0) || !m_in_pkt && ($urandom_range(0, 4) != 0);
         e = ($urandom_range(0, 5) == 0);
         rd = DW'({$urandom(), $urandom(), $urandom()});
         step(v, s, e, PW'($urandom_range(0, PN - 1)), rd,
              PN'($urandom_range(0, 3) == 0 ? $urandom() : 0),
              PN'($urandom_range(0, 7) == 0 ? $urandom() : 0),
              1, xw, xt, xo);
      end

      // reset in the middle of a packet
      step(1, 1, 0, 1, 72'h51, 2'b00, 2'b00, 1, xw, xt, xo);
      in_vld = 1; in_sop = 0; in_eop = 0; in_data = 72'h52;
      #1 resetw = 1'b1;
      #1;
      chk("rst_mid_wr", 128'(wr), 128'(0));
      chk("rst_mid_drop", 128'(drop_cntx), 128'(0));
      chk("rst_mid_rdy", 128'(in_rdy), 128'(0));
      m_reset();
      @(negedge clksw);
      resetw = 1'b0;
      step(1, 0, 0, 1, 72'h53, 2'b00, 2'b00, 1, xw, xt, xo);
      step(1, 0, 1, 1, 72'h54, 2'b00, 2'b00, 1, xw, xt, xo);
      chk("post_rst_orphan", 128'(orphan_err), 128'(1));
      step(1, 1, 1, 0, 72'h55, 2'b00, 2'b00, 1, xw, xt, xo);
      chk("post_rst_wr", 128'(wr), 128'(1));
      chk("post_rst_wdata", 128'(wdata), 128'(72'h55));

      // drop counter saturation
      for (int i = 0; i < 65538; i++)
         step(1, 1, 1, 0, DW'(i), 2'b01, 2'b00, 0, xw, xt, xo);
      chk("sat_quiet", 128'(quiet_err), 128'(0));
      chk("sat_cnt0", 128'(drop_cntx[15:0]), 128'(16'hFFFF));
      chk("sat_cnt1", 128'(drop_cntx[31:16]), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
